control_pid_secuencial: RTL

- Fixed-point PID sequencer for the servomotor position loop.
- On each sample tick it computes the error, integral and derivative terms.
- It time-shares one multiplier across the Kp, Ki and Kd products, then sums the three with saturation.
- It presents a registered control word u with a one-cycle valid pulse, replacing per-term multipliers in the controller datapath.

---
 rtl/control_pid_secuencial_pkg.sv | 59 +++++
 rtl/control_pid_secuencial_mult_punto_fijo_sat.sv | 41 ++++
 rtl/control_pid_secuencial.sv | 139 +++++++++++++
 3 files changed

// File: rtl/control_pid_secuencial_pkg.sv
// ============================================================================
// Module      : control_pid_secuencial_pkg
// Description : Shared state encoding, width rules and saturating arithmetic
//               for the sequential PID controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package control_pid_secuencial_pkg;

  localparam int WIDE = 64;
  typedef logic signed [WIDE-1:0] wide_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURA = 3'd1,
    MUL_P   = 3'd2,
    MUL_I   = 3'd3,
    MUL_D   = 3'd4,
    SUMA    = 3'd5
  } estado_t;

  function automatic int prod_w(input int n);
    return 2 * n;
  endfunction

  function automatic int suma_w(input int n);
    return n + 2;
  endfunction

  function automatic wide_t sat_max(input int n);
    return (wide_t'(1) <<< (n - 1)) - wide_t'(1);
  endfunction

  function automatic wide_t sat_min(input int n);
    return -(wide_t'(1) <<< (n - 1));
  endfunction

  // Operands arrive sign-extended to WIDE bits, so the raw result never wraps
  function automatic wide_t sat_clamp(input wide_t x, input int n);
    if (x > sat_max(n))
      return sat_max(n);
    else if (x < sat_min(n))
      return sat_min(n);
    else
      return x;
  endfunction

  function automatic wide_t sat_add(input wide_t a, input wide_t b, input int n);
    return sat_clamp(a + b, n);
  endfunction

  function automatic wide_t sat_sub(input wide_t a, input wide_t b, input int n);
    return sat_clamp(a - b, n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/control_pid_secuencial_mult_punto_fijo_sat.sv
// ============================================================================
// Module      : mult_punto_fijo_sat
// Description : Combinational signed fixed-point multiply, fractional shift
//               and saturation back to the word width.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_punto_fijo_sat
  import control_pid_secuencial_pkg::*;
#(
  parameter int N       = 19,
  parameter int DECIMAL = 0
) (
  input  logic signed [N-1:0] a,
  input  logic signed [N-1:0] b,
  output logic signed [N-1:0] p
);

  localparam int c_prod_w = prod_w(N);

  logic signed [c_prod_w-1:0] w_a_ext;
  logic signed [c_prod_w-1:0] w_b_ext;
  logic signed [c_prod_w-1:0] w_prod;
  logic signed [c_prod_w-1:0] w_desp;
  wide_t                      w_sat;
  logic                       w_unused_bits;

  assign w_a_ext = {{N{a[N-1]}}, a};
  assign w_b_ext = {{N{b[N-1]}}, b};
  assign w_prod  = w_a_ext * w_b_ext;
  // Arithmetic shift truncates toward minus infinity
  assign w_desp  = w_prod >>> DECIMAL;
  assign w_sat   = sat_clamp(wide_t'(w_desp), N);
  assign p       = w_sat[N-1:0];

  assign w_unused_bits = ^w_sat[WIDE-1:N];

endmodule

`default_nettype wire

// File: rtl/control_pid_secuencial.sv
// ============================================================================
// Module      : control_pid_secuencial
// Description : Sequential fixed-point PID with one shared saturating
//               multiplier; one control word per sample pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_pid_secuencial
  import control_pid_secuencial_pkg::*;
#(
  parameter int MAGNITUD = 18,
  parameter int DECIMAL  = 0,
  parameter int N        = MAGNITUD + DECIMAL + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                muestra,
  input  logic signed [N-1:0] referencia,
  input  logic signed [N-1:0] medicion,
  input  logic signed [N-1:0] kp,
  input  logic signed [N-1:0] ki,
  input  logic signed [N-1:0] kd,
  output logic signed [N-1:0] u,
  output logic                listo,
  output logic                ocupado
);

  localparam int c_suma_w = suma_w(N);

  estado_t             r_estado;
  logic signed [N-1:0] r_ref, r_med, r_kp, r_ki, r_kd;
  logic signed [N-1:0] r_acc, r_eprev, r_dif;
  logic signed [N-1:0] r_p, r_i, r_d;

  wide_t                      w_e_w, w_dif_w, w_acc_w, w_u_w;
  logic signed [N-1:0]        w_e;
  logic signed [c_suma_w-1:0] w_suma;
  logic signed [N-1:0]        w_op_a, w_op_b, w_prod;
  logic                       w_unused_bits;

  assign w_e_w   = sat_sub(wide_t'(r_ref), wide_t'(r_med), N);
  assign w_e     = w_e_w[N-1:0];
  assign w_dif_w = sat_sub(wide_t'(w_e), wide_t'(r_eprev), N);
  assign w_acc_w = sat_add(wide_t'(r_acc), wide_t'(w_e), N);

  // Two guard bits make the three-term sum exact before clamping
  assign w_suma = {{2{r_p[N-1]}}, r_p} + {{2{r_i[N-1]}}, r_i} + {{2{r_d[N-1]}}, r_d};
  assign w_u_w  = sat_clamp(wide_t'(w_suma), N);

  assign w_unused_bits = ^{w_e_w[WIDE-1:N], w_dif_w[WIDE-1:N],
                           w_acc_w[WIDE-1:N], w_u_w[WIDE-1:N]};

  // e_prev already holds the current error once CAPTURA has retired
  always_comb begin
    w_op_a = r_kp;
    w_op_b = r_eprev;
    case (r_estado)
      MUL_I:   begin w_op_a = r_ki; w_op_b = r_acc; end
      MUL_D:   begin w_op_a = r_kd; w_op_b = r_dif; end
      default: ;
    endcase
  end

  mult_punto_fijo_sat #(
    .N       (N),
    .DECIMAL (DECIMAL)
  ) u_mult (
    .a (w_op_a),
    .b (w_op_b),
    .p (w_prod)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_estado <= IDLE;
      r_ref    <= '0;
      r_med    <= '0;
      r_kp     <= '0;
      r_ki     <= '0;
      r_kd     <= '0;
      r_acc    <= '0;
      r_eprev  <= '0;
      r_dif    <= '0;
      r_p      <= '0;
      r_i      <= '0;
      r_d      <= '0;
      u        <= '0;
      listo    <= 1'b0;
      ocupado  <= 1'b0;
    end else begin
      listo <= 1'b0;
      case (r_estado)
        IDLE: begin
          if (muestra) begin
            r_ref    <= referencia;
            r_med    <= medicion;
            r_kp     <= kp;
            r_ki     <= ki;
            r_kd     <= kd;
            ocupado  <= 1'b1;
            r_estado <= CAPTURA;
          end
        end
        CAPTURA: begin
          r_dif    <= w_dif_w[N-1:0];
          r_acc    <= w_acc_w[N-1:0];
          r_eprev  <= w_e;
          r_estado <= MUL_P;
        end
        MUL_P: begin
          r_p      <= w_prod;
          r_estado <= MUL_I;
        end
        MUL_I: begin
          r_i      <= w_prod;
          r_estado <= MUL_D;
        end
        MUL_D: begin
          r_d      <= w_prod;
          r_estado <= SUMA;
        end
        SUMA: begin
          u        <= w_u_w[N-1:0];
          listo    <= 1'b1;
          ocupado  <= 1'b0;
          r_estado <= IDLE;
        end
        default: begin
          ocupado  <= 1'b0;
          r_estado <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
